// File: rtl/wb_data_master_if.sv
// Data-memory bus bundle between the CPU-side initiator (master) and the memory responder (slave).
// ack_i may be driven combinationally from stb_o by the responder.
interface wb_data_master_if;
  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        we_o;
  logic        stb_o;
  logic [3:0]  sel_o;
  logic        signext_o;
  logic        ack_i;

  modport master (
    output adr_o, dat_o, we_o, stb_o, sel_o, signext_o,
    input  dat_i, ack_i
  );

  modport slave (
    input  adr_o, dat_o, we_o, stb_o, sel_o, signext_o,
    output dat_i, ack_i
  );
endinterface

// File: rtl/wb_data_master.sv
// Initiator for CPU load/store traffic: one bus cycle per request, read extension, timeout/size errors.
// Define ALIGN_CHECK_EN to reject misaligned half/word accesses without issuing a bus cycle.
module wb_data_master #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TW             = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [1:0]              cpu_size,
  input  logic                    cpu_unsigned,
  input  logic [31:0]             cpu_addr,
  input  logic [31:0]             cpu_wdata,
  output logic                    cpu_stall,
  output logic                    cpu_done,
  output logic [31:0]             cpu_rdata,
  output logic                    cpu_err,
  wb_data_master_if.master        bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_t;

  // A zero TIMEOUT_CYCLES keeps the counter running but never aborts.
  localparam bit            TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t        state_q;
  state_t        state_d;
  size_t         size_q;
  logic [TW-1:0] to_cnt_q;

  logic req_illegal;
  logic req_misaligned;
  logic req_reject;
  logic to_hit;

  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    logic [3:0] m;
    m = 4'b0000;
    case (sz)
      SZ_BYTE: m = 4'b0001;
      SZ_HALF: m = 4'b0011;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Unsigned requests zero-fill; signed ones replicate the top bit of the accessed lane.
  function automatic logic [31:0] extend_rdata(input logic [31:0] d, input size_t sz,
                                               input logic uns);
    logic [31:0] r;
    r = d;
    case (sz)
      SZ_BYTE: r = {{24{~uns & d[7]}},  d[7:0]};
      SZ_HALF: r = {{16{~uns & d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  assign req_illegal = (cpu_size == SZ_ILL);

`ifdef ALIGN_CHECK_EN
  assign req_misaligned = ((cpu_size == SZ_HALF) && cpu_addr[0]) ||
                          ((cpu_size == SZ_WORD) && (cpu_addr[1:0] != 2'b00));
`else
  assign req_misaligned = 1'b0;
`endif

  assign req_reject = req_illegal | req_misaligned;
  assign to_hit     = TO_EN && (to_cnt_q == TO_LAST);
  assign cpu_stall  = cpu_req & ~cpu_done;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          state_d = req_reject ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (bus.ack_i || to_hit) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.stb_o     <= 1'b0;
      bus.we_o      <= 1'b0;
      bus.sel_o     <= 4'b0000;
      bus.adr_o     <= 32'h0;
      bus.dat_o     <= 32'h0;
      bus.signext_o <= 1'b0;
      cpu_done      <= 1'b0;
      cpu_err       <= 1'b0;
      cpu_rdata     <= 32'h0;
      size_q        <= SZ_BYTE;
      to_cnt_q      <= '0;
    end else begin
      cpu_done <= 1'b0;
      case (state_q)
        IDLE: begin
          to_cnt_q <= '0;
          if (cpu_req) begin
            if (req_reject) begin
              cpu_done  <= 1'b1;
              cpu_err   <= 1'b1;
              cpu_rdata <= 32'h0;
            end else begin
              bus.stb_o     <= 1'b1;
              bus.we_o      <= cpu_we;
              bus.sel_o     <= size_mask(cpu_size);
              bus.adr_o     <= cpu_addr;
              bus.dat_o     <= cpu_wdata;
              bus.signext_o <= cpu_unsigned;
              size_q        <= size_t'(cpu_size);
            end
          end
        end
        BUSY: begin
          if (bus.ack_i) begin
            // we_o still holds the request direction at this edge.
            bus.stb_o <= 1'b0;
            bus.we_o  <= 1'b0;
            bus.sel_o <= 4'b0000;
            cpu_done  <= 1'b1;
            cpu_err   <= 1'b0;
            cpu_rdata <= bus.we_o ? 32'h0 : extend_rdata(bus.dat_i, size_q, bus.signext_o);
          end else begin
            to_cnt_q <= to_cnt_q + TW'(1);
            if (to_hit) begin
              bus.stb_o <= 1'b0;
              cpu_done  <= 1'b1;
              cpu_err   <= 1'b1;
              cpu_rdata <= 32'h0;
            end
          end
        end
        RESP: begin
          to_cnt_q <= '0;
        end
        default: begin
          to_cnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_data_master.sv
// Randomized bench for wb_data_master: per-transaction timeline model checked every cycle,
// plus directed load/store/timeout/reset scenarios pinned to hand-computed values.
module tb_wb_data_master;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [1:0]  cpu_size;
  logic        cpu_unsigned;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic        cpu_done;
  logic [31:0] cpu_rdata;
  logic        cpu_err;

  wb_data_master_if bus();

  wb_data_master #(.TIMEOUT_CYCLES(TO), .TW(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_size     (cpu_size),
    .cpu_unsigned (cpu_unsigned),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_stall    (cpu_stall),
    .cpu_done     (cpu_done),
    .cpu_rdata    (cpu_rdata),
    .cpu_err      (cpu_err),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  // Responder: acks after wait_n strobed cycles when enabled; ack_force pulses ack unconditionally.
  bit          ack_en    = 1'b0;
  bit          ack_force = 1'b0;
  int          wait_n    = 0;
  int          busy_cnt  = 0;
  logic [31:0] rd_val    = 32'h0;
  logic [31:0] junk      = 32'h0;

  always @(posedge clk) busy_cnt <= (bus.stb_o && !bus.ack_i) ? busy_cnt + 1 : 0;
  assign bus.ack_i = ack_force | (ack_en & bus.stb_o & (busy_cnt == wait_n));
  assign bus.dat_i = bus.ack_i ? rd_val : junk;

  typedef struct packed {
    logic        stall;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        sx;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_cmp;
  bit   model_on = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] model_extend(input logic [31:0] d, input logic [1:0] size,
                                               input bit uns);
    case (size)
      2'b00:   return uns ? 32'(d[7:0])  : 32'($signed(d[7:0]));
      2'b01:   return uns ? 32'(d[15:0]) : 32'($signed(d[15:0]));
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] model_mask(input logic [1:0] size);
    case (size)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Single compare process: every modelled cycle is checked against its expectation.
  always @(negedge clk) begin
    if (model_on) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL exp_queue: no expectation queued at %0t", $time);
      end else begin
        e_cmp = exp_q.pop_front();
        check("cpu_stall", 32'(cpu_stall), 32'(e_cmp.stall));
        check("cpu_done",  32'(cpu_done),  32'(e_cmp.done));
        check("stb_o",     32'(bus.stb_o), 32'(e_cmp.stb));
        if (e_cmp.done) begin
          check("cpu_err",   32'(cpu_err), 32'(e_cmp.err));
          check("cpu_rdata", cpu_rdata,    e_cmp.rdata);
        end
        if (e_cmp.stb) begin
          check("we_o",      32'(bus.we_o),      32'(e_cmp.we));
          check("sel_o",     32'(bus.sel_o),     32'(e_cmp.sel));
          check("adr_o",     bus.adr_o,          e_cmp.adr);
          check("dat_o",     bus.dat_o,          e_cmp.dat);
          check("signext_o", 32'(bus.signext_o), 32'(e_cmp.sx));
        end
      end
    end
  end

  // Observations of the most recent transaction, for the directed literal checks.
  int          obs_done_at;
  int          obs_stb_cnt;
  logic [31:0] obs_rdata, obs_adr, obs_dat;
  logic        obs_err, obs_we, obs_sx;
  logic [3:0]  obs_sel;

  task automatic idle_cycle();
    exp_t e;
    @(posedge clk); #1;
    cpu_req      = 1'b0;
    cpu_we       = 1'($urandom);
    cpu_size     = 2'($urandom);
    cpu_unsigned = 1'($urandom);
    cpu_addr     = $urandom;
    cpu_wdata    = $urandom;
    ack_en       = 1'b0;
    e = '0;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // waits < 0 means the responder never acks.
  task automatic run_txn(input bit we, input logic [1:0] size, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rd, input int waits, input int gap);
    bit          reject, ok;
    int          done_at, stb_last;
    logic [31:0] exp_rd;
    exp_t        e;
    reject = (size == 2'b11);
`ifdef ALIGN_CHECK_EN
    if (size == 2'b01 && addr[0]) reject = 1'b1;
    if (size == 2'b10 && addr[1:0] != 2'b00) reject = 1'b1;
`endif
    ok = !reject && waits >= 0 && waits < TO;
    if (reject) begin
      done_at = 1; stb_last = 0;
    end else if (ok) begin
      done_at = waits + 2; stb_last = waits + 1;
    end else begin
      done_at = TO + 1; stb_last = TO;
    end
    exp_rd = (ok && !we) ? model_extend(rd, size, uns) : 32'h0;
    obs_done_at = -1; obs_stb_cnt = 0; obs_rdata = 'x; obs_err = 1'bx;
    obs_adr = 'x; obs_dat = 'x; obs_we = 1'bx; obs_sx = 1'bx; obs_sel = 'x;
    for (int c = 0; c <= done_at; c++) begin
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = we; cpu_size = size; cpu_unsigned = uns;
      cpu_addr = addr; cpu_wdata = wdata;
      ack_en = (waits >= 0); wait_n = waits; rd_val = rd; junk = $urandom;
      e.stall = (c != done_at);
      e.done  = (c == done_at);
      e.err   = !ok;
      e.rdata = exp_rd;
      e.stb   = (c >= 1 && c <= stb_last);
      e.we    = we;
      e.sel   = model_mask(size);
      e.adr   = addr;
      e.dat   = wdata;
      e.sx    = uns;
      exp_q.push_back(e);
      @(negedge clk);
      if (bus.stb_o) begin
        if (obs_stb_cnt == 0) begin
          obs_adr = bus.adr_o; obs_dat = bus.dat_o; obs_we = bus.we_o;
          obs_sel = bus.sel_o; obs_sx = bus.signext_o;
        end
        obs_stb_cnt++;
      end
      if (cpu_done && obs_done_at < 0) begin
        obs_done_at = c; obs_rdata = cpu_rdata; obs_err = cpu_err;
      end
    end
    for (int g = 0; g < gap; g++) idle_cycle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = 2'b00; cpu_unsigned = 1'b0;
    cpu_addr = 32'h0; cpu_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stb_o",     32'(bus.stb_o),     32'h0);
    check("rst_we_o",      32'(bus.we_o),      32'h0);
    check("rst_sel_o",     32'(bus.sel_o),     32'h0);
    check("rst_adr_o",     bus.adr_o,          32'h0);
    check("rst_dat_o",     bus.dat_o,          32'h0);
    check("rst_signext_o", 32'(bus.signext_o), 32'h0);
    check("rst_cpu_done",  32'(cpu_done),      32'h0);
    check("rst_cpu_err",   32'(cpu_err),       32'h0);
    check("rst_cpu_rdata", cpu_rdata,          32'h0);
    check("rst_cpu_stall", 32'(cpu_stall),     32'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #1 model_on = 1'b1;

    // Word store, zero wait.
    run_txn(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 0, 1);
    check("st_done_at", 32'(obs_done_at), 32'd2);
    check("st_err",     32'(obs_err),     32'h0);
    check("st_stb_cnt", 32'(obs_stb_cnt), 32'd1);
    check("st_we",      32'(obs_we),      32'h1);
    check("st_sel",     32'(obs_sel),     32'hF);
    check("st_adr",     obs_adr,          32'h0000_0010);
    check("st_dat",     obs_dat,          32'hDEAD_BEEF);

    // Signed half load, three wait states.
    run_txn(1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0, 32'h0000_8001, 3, 0);
    check("lh_rdata",   obs_rdata,        32'hFFFF_8001);
    check("lh_done_at", 32'(obs_done_at), 32'd5);
    check("lh_sel",     32'(obs_sel),     32'h3);
    check("lh_stb_cnt", 32'(obs_stb_cnt), 32'd4);

    // Byte loads, unsigned then signed.
    run_txn(1'b0, 2'b00, 1'b1, 32'h0000_0021, 32'h0, 32'h0000_00F0, 0, 0);
    check("lbu_sx",    32'(obs_sx), 32'h1);
    check("lbu_rdata", obs_rdata,   32'h0000_00F0);
    run_txn(1'b0, 2'b00, 1'b0, 32'h0000_0021, 32'h0, 32'h0000_00F0, 1, 1);
    check("lb_sx",     32'(obs_sx), 32'h0);
    check("lb_rdata",  obs_rdata,   32'hFFFF_FFF0);

    // Timeout with no ack, then a normal load right after.
    run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'h0, -1, 0);
    check("to_stb_cnt", 32'(obs_stb_cnt), 32'd4);
    check("to_done_at", 32'(obs_done_at), 32'd5);
    check("to_err",     32'(obs_err),     32'h1);
    check("to_rdata",   obs_rdata,        32'h0);
    run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0, 32'h1234_5678, 0, 0);
    check("post_to_err",   32'(obs_err), 32'h0);
    check("post_to_rdata", obs_rdata,    32'h1234_5678);

    // Ack on the last cycle before the timeout still wins.
    run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0108, 32'h0, 32'hCAFE_0001, TO - 1, 0);
    check("late_ack_err", 32'(obs_err), 32'h0);

    // Illegal size.
    run_txn(1'b0, 2'b11, 1'b0, 32'h0000_0040, 32'h0, 32'h0, 0, 0);
    check("ill_stb_cnt", 32'(obs_stb_cnt), 32'd0);
    check("ill_done_at", 32'(obs_done_at), 32'd1);
    check("ill_err",     32'(obs_err),     32'h1);

    // Misaligned word load.
    run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0013, 32'h0, 32'h5555_AAAA, 0, 1);
`ifdef ALIGN_CHECK_EN
    check("mis_stb_cnt", 32'(obs_stb_cnt), 32'd0);
    check("mis_err",     32'(obs_err),     32'h1);
    check("mis_rdata",   obs_rdata,        32'h0);
`else
    check("mis_stb_cnt", 32'(obs_stb_cnt), 32'd1);
    check("mis_adr",     obs_adr,          32'h0000_0013);
    check("mis_err",     32'(obs_err),     32'h0);
`endif
    #1 model_on = 1'b0;

    // Reset in the middle of a bus cycle, then a stray ack.
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'b10; cpu_addr = 32'h0000_0200; ack_en = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rb_stb_before", 32'(bus.stb_o), 32'h1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; cpu_req = 1'b0; ack_force = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rb_stb_after",  32'(bus.stb_o), 32'h0);
      check("rb_no_done",    32'(cpu_done),  32'h0);
      @(posedge clk); #1 ack_force = 1'b0;
    end
    @(negedge clk); #1 model_on = 1'b1;

    // Randomized traffic.
    for (int t = 0; t < 200; t++) begin
      int          r, w;
      logic [1:0]  sz;
      r  = int'($urandom_range(0, 7));
      sz = (r == 7) ? 2'b11 : 2'(r % 3);
      w  = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 5));
      run_txn(1'($urandom), sz, 1'($urandom), $urandom, $urandom, $urandom, w,
              int'($urandom_range(0, 2)));
    end
    idle_cycle();
    #1 model_on = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/wb_data_master.md
Name: wb_data_master

Overview:
- Initiator end of the data-memory bus. The CPU MEM stage issues load/store requests; this block drives stb/we/adr/sel/dat toward the memory responder and waits for ack.
- It also extracts and extends read data, stalls the CPU for the duration of each transaction, and reports errors: bus timeout, illegal size, and (optionally) misalignment.

Parameters:
- TIMEOUT_CYCLES, 255: BUSY cycles without ack before abort. 0 disables the timeout.
- TW, 8: width of the timeout counter. Must satisfy TIMEOUT_CYCLES < 2^TW.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- cpu_req  in  1  request valid. Held high until cpu_done.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- cpu_unsigned  in  1  1 = zero-extend the load (lbu/lhu).
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  store data, right-justified.
- cpu_stall  out  1  freeze the pipeline.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_rdata  out  32  extended load data. Valid while cpu_done is high.
- cpu_err  out  1  error flag. Valid while cpu_done is high.
- adr_o  out  32  bus byte address.
- dat_o  out  32  bus write data, right-justified.
- dat_i  in  32  bus read data, right-justified.
- we_o  out  1  bus write enable.
- stb_o  out  1  bus strobe.
- sel_o  out  4  unshifted size mask: 0001 byte, 0011 half, 1111 word. The responder shifts it by adr[1:0].
- signext_o  out  1  copy of the latched cpu_unsigned, passed to the responder's extension control.
- ack_i  in  1  responder acknowledge. May be combinational from stb_o.

Behaviour:
- Reset values:
  - Registered outputs: stb_o=0, we_o=0, sel_o=0, adr_o=0, dat_o=0, signext_o=0, cpu_done=0, cpu_err=0, cpu_rdata=0.
  - State = IDLE; timeout counter = 0.
  - cpu_stall is combinational (defined below), so it reads 0 during reset whenever cpu_req=0.
- FSM states: IDLE, BUSY, RESP.
- IDLE with cpu_req=1 and a legal request:
  - latch addr, we, size, unsigned and wdata into the bus registers;
  - set stb_o=1; go to BUSY.
- IDLE with cpu_req=1 and cpu_size=11: no bus cycle; go to RESP with err=1.
- BUSY:
  - adr_o/dat_o/we_o/sel_o/signext_o stay stable while stb_o=1.
  - ack_i sampled 1 at posedge: stb_o←0, we_o←0, sel_o←0. If it was a load, capture the extended read data into cpu_rdata (err=0). Go to RESP.
  - No ack: counter increments. If TIMEOUT_CYCLES≠0 and counter==TIMEOUT_CYCLES−1 at that edge: stb_o←0, cpu_rdata←0, err←1, go to RESP.
- RESP: cpu_done=1 and cpu_err valid for exactly one cycle; cpu_req is ignored; next state IDLE; counter cleared.
- Latency:
  - Zero-wait responder: request seen in cycle 0, stb_o high in cycle 1, cpu_done in cycle 2, next request accepted in cycle 3.
  - Each wait state adds one cycle.
- cpu_stall = cpu_req & ~cpu_done.
- Read extraction from dat_i:
  - byte: dat_i[7:0], zero-extended if unsigned, else sign-extended from bit 7.
  - half: dat_i[15:0], extended from bit 15 by the same rule.
  - word: unchanged.
- Stores: cpu_rdata←0, err=0.
- ack_i is ignored in IDLE and RESP.
- rst while BUSY: stb_o is 0 after that edge, state IDLE, no cpu_done pulse. A late ack is ignored.

Optional Feature:
- Macro ALIGN_CHECK_EN.
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]≠00, issues no bus cycle and goes IDLE→RESP with cpu_err=1, cpu_rdata=0 (latency 1 cycle to done).
- Undefined: misaligned requests are issued unchanged. adr_o carries the full address and the responder handles the offsets.

Test Plan:
- Word store, zero-wait: addr 0x0000_0010, wdata 0xDEAD_BEEF → cycle 1 has stb_o=1, we_o=1, sel_o=1111, adr_o=0x10, dat_o=0xDEADBEEF; cycle 2 has cpu_done=1, err=0; cpu_stall high in cycles 0–1.
- Load half signed, 3 wait states: addr 0x12, dat_i=0x0000_8001 at ack → sel_o=0011 until ack; cpu_rdata=0xFFFF_8001 at done; done occurs 3 cycles later than in the zero-wait case.
- Load byte unsigned: dat_i=0x0000_00F0 → signext_o=1, cpu_rdata=0x0000_00F0. Same load signed → cpu_rdata=0xFFFF_FFF0.
- Timeout, TIMEOUT_CYCLES=4, ack never asserted → stb_o high for exactly 4 cycles, then cpu_done=1, cpu_err=1, cpu_rdata=0; the next request proceeds normally.
- Illegal size 11 → stb_o never asserted; cpu_done+err one cycle after the request.
- rst mid-BUSY, then ack_i pulsed → stb_o=0 after the reset edge, no cpu_done.
- With ALIGN_CHECK_EN: word load at 0x13 → no stb_o, err at done.
- Without ALIGN_CHECK_EN: word load at 0x13 → bus cycle with adr_o=0x13.
